// File: rtl/booth_mult_scheduler_if.sv
// Request/response and multiplier-pin bundle for booth_mult_scheduler.
// The scheduler uses the slave modport; requesters plus the multiplier sit on master.
interface booth_mult_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  rsp_err;
  logic                  mult_load;
  logic [WIDTH-1:0]      mult_multiplicand;
  logic [WIDTH-1:0]      mult_multiplier;
  logic [2*WIDTH-1:0]    mult_product;
  logic                  mult_done;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mult_product, mult_done,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
           mult_load, mult_multiplicand, mult_multiplier, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mult_product, mult_done,
    input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err,
           mult_load, mult_multiplicand, mult_multiplier, busy
  );
endinterface

// File: rtl/booth_mult_scheduler.sv
// Round-robin scheduler sharing one booth_multiplier among NREQ requesters.
// Define MULT_TIMEOUT_EN to add a RUN-state watchdog that aborts with rsp_err.
module booth_mult_scheduler #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  booth_mult_scheduler_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int LCW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_RESP} state_t;

  state_t             state_reg;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [IDW-1:0]     id_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [LCW-1:0]     load_cnt_reg;
  logic               first_reg;
  logic               mult_load_reg;
  logic               rsp_valid_reg;
  logic [IDW-1:0]     rsp_id_reg;
  logic [2*WIDTH-1:0] rsp_product_reg;

  logic [WIDTH-1:0]   a_arr [NREQ];
  logic [WIDTH-1:0]   b_arr [NREQ];
  logic [IDW-1:0]     grant;
  logic               any_valid;
  logic [IDW-1:0]     next_ptr;
  int                 cand;

  // Cyclic search from rr_ptr; scanning offsets high-to-low leaves the nearest hit.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.req_valid[IDW'(cand)]) begin
        grant     = IDW'(cand);
        any_valid = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
    assign bus.req_ready[gi] = !reset && (state_reg == ST_IDLE) && any_valid &&
                               (grant == IDW'(gi));
  end

  assign next_ptr = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;

  // Parameters outside their legal range leave this marker block in the hierarchy.
  if (LOAD_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
  end

`ifdef MULT_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TCW-1:0] tmo_cnt_reg;
  logic           err_reg;
  assign bus.rsp_err = err_reg;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      rr_ptr_reg      <= '0;
      id_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      load_cnt_reg    <= '0;
      first_reg       <= 1'b0;
      mult_load_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
`ifdef MULT_TIMEOUT_EN
      tmo_cnt_reg     <= '0;
      err_reg         <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (any_valid) begin
            id_reg        <= grant;
            a_reg         <= a_arr[grant];
            b_reg         <= b_arr[grant];
            load_cnt_reg  <= '0;
            mult_load_reg <= 1'b1;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (load_cnt_reg == LCW'(LOAD_CYCLES - 1)) begin
            mult_load_reg <= 1'b0;
            first_reg     <= 1'b1;
`ifdef MULT_TIMEOUT_EN
            tmo_cnt_reg   <= '0;
`endif
            state_reg     <= ST_RUN;
          end else begin
            load_cnt_reg  <= load_cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          first_reg <= 1'b0;
          // done left over from the previous operation is masked on the first cycle
          if (!first_reg && bus.mult_done) begin
            rsp_product_reg <= bus.mult_product;
            rsp_id_reg      <= id_reg;
            rsp_valid_reg   <= 1'b1;
`ifdef MULT_TIMEOUT_EN
            err_reg         <= 1'b0;
`endif
            state_reg       <= ST_RESP;
          end
`ifdef MULT_TIMEOUT_EN
          else if (tmo_cnt_reg == TCW'(TIMEOUT - 1)) begin
            rsp_product_reg <= '0;
            rsp_id_reg      <= id_reg;
            rsp_valid_reg   <= 1'b1;
            err_reg         <= 1'b1;
            state_reg       <= ST_RESP;
          end else begin
            tmo_cnt_reg     <= tmo_cnt_reg + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= next_ptr;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy              = (state_reg != ST_IDLE);
  assign bus.mult_load         = mult_load_reg;
  assign bus.mult_multiplicand = a_reg;
  assign bus.mult_multiplier   = b_reg;
  assign bus.rsp_valid         = rsp_valid_reg;
  assign bus.rsp_id            = rsp_id_reg;
  assign bus.rsp_product       = rsp_product_reg;
endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Scoreboard bench for booth_mult_scheduler with a 4-cycle behavioural multiplier.
// Expected responses are queued at grant time and popped by a negedge monitor.
module tb_booth_mult_scheduler;
  localparam int NREQ = 4, WIDTH = 4, LOAD_CYCLES = 2, TIMEOUT = 15, MLAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  booth_mult_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();

  booth_mult_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .LOAD_CYCLES(LOAD_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] prod;
    logic       err;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  logic [NREQ-1:0] pending = '0;
  logic [3:0]      op_a [NREQ];
  logic [3:0]      op_b [NREQ];
  bit              acc_flag [NREQ];
  bit              rsp_rdy = 1'b1;
  bit              reissue = 1'b0;
  bit              rand_mode = 1'b0;
  bit              stuck = 1'b0;

  // reference model state
  bit         m_busy = 1'b0;
  int         m_ptr = 0;
  bit         seen_valid = 1'b0;
  int         acc_cyc = 0;
  int         load_seen = 0;
  logic [1:0] h_id;
  logic [7:0] h_prod;
  logic       h_err;
  int         last_id = -1;
  logic [7:0] last_prod = '0;
  logic       last_err = 1'b0;
  int              mon_g;
  logic [NREQ-1:0] mon_rdy;
  exp_t            mon_e;

  function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] x, y;
    x = {{4{a[3]}}, a};
    y = {{4{b[3]}}, b};
    return 8'(x * y);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // behavioural multiplier: product appears MLAT cycles after load falls
  logic [7:0] m_prod;
  logic       m_done;
  int         m_cnt;
  assign bus.mult_product = m_prod;
  assign bus.mult_done    = m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= MLAT;
      m_done <= 1'b0;
      m_prod <= '0;
    end else if (bus.mult_load) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_prod <= 8'hA5;
    end else if (m_cnt < MLAT) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == MLAT - 1 && !stuck) begin
        m_done <= 1'b1;
        m_prod <= smul(bus.mult_multiplicand, bus.mult_multiplier);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      chk(bus.rsp_valid == 0 && bus.busy == 0 && bus.mult_load == 0 && bus.req_ready == 0,
          "reset_ctrl", {bus.rsp_valid, bus.busy, bus.mult_load, bus.req_ready}, 0);
      chk({bus.rsp_id, bus.rsp_product, bus.rsp_err, bus.mult_multiplicand, bus.mult_multiplier} == 0,
          "reset_data", {bus.rsp_id, bus.rsp_product, bus.rsp_err, bus.mult_multiplicand,
          bus.mult_multiplier}, 0);
      m_busy = 1'b0;
      m_ptr = 0;
      seen_valid = 1'b0;
      exp_q.delete();
    end else begin
      mon_rdy = '0;
      mon_g = -1;
      if (!m_busy) begin
        mon_g = pick(bus.req_valid, m_ptr);
        if (mon_g >= 0) mon_rdy[mon_g] = 1'b1;
      end
      chk(bus.req_ready == mon_rdy, "req_ready", bus.req_ready, mon_rdy);
      chk(bus.busy == m_busy, "busy", bus.busy, m_busy);
      if (bus.mult_load) load_seen++;
      if (mon_g >= 0) begin
        exp_q.push_back('{id: mon_g, prod: stuck ? 8'h00 : smul(op_a[mon_g], op_b[mon_g]),
                          err: stuck, lat: stuck ? LOAD_CYCLES + 1 + TIMEOUT : LOAD_CYCLES + MLAT + 2});
        m_busy = 1'b1;
        acc_flag[mon_g] = 1'b1;
        acc_cyc = cyc;
        load_seen = 0;
        grant_log.push_back(mon_g);
      end
      if (bus.rsp_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          h_id = bus.rsp_id;
          h_prod = bus.rsp_product;
          h_err = bus.rsp_err;
          if (exp_q.size() > 0)
            chk(cyc - acc_cyc == exp_q[0].lat, "rsp_latency", cyc - acc_cyc, exp_q[0].lat);
          chk(load_seen == LOAD_CYCLES, "load_cycles", load_seen, LOAD_CYCLES);
        end else begin
          chk(bus.rsp_id == h_id && bus.rsp_product == h_prod && bus.rsp_err == h_err,
              "rsp_hold", {bus.rsp_id, bus.rsp_product, bus.rsp_err}, {h_id, h_prod, h_err});
        end
        if (bus.rsp_ready) begin
          chk(exp_q.size() > 0, "rsp_expected", exp_q.size(), 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk(int'(bus.rsp_id) == mon_e.id, "rsp_id", bus.rsp_id, mon_e.id);
            chk(bus.rsp_product == mon_e.prod, "rsp_product", bus.rsp_product, mon_e.prod);
            chk(bus.rsp_err == mon_e.err, "rsp_err", bus.rsp_err, mon_e.err);
            m_ptr = (mon_e.id + 1) % NREQ;
          end
          last_id = int'(bus.rsp_id);
          last_prod = bus.rsp_product;
          last_err = bus.rsp_err;
          $display("rsp id=%0d product=0x%02h err=%0d cycle=%0d",
                   bus.rsp_id, bus.rsp_product, bus.rsp_err, cyc);
          m_busy = 1'b0;
          seen_valid = 1'b0;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
      bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
    end
    bus.req_valid = pending;
    bus.rsp_ready = rsp_rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 1'b0;
        if (reissue) begin
          op_a[i] = 4'($urandom);
          op_b[i] = 4'($urandom);
        end else begin
          pending[i] = 1'b0;
        end
      end
      if (rand_mode) begin
        if (!pending[i] && $urandom_range(0, 3) == 0) begin
          pending[i] = 1'b1;
          op_a[i] = 4'($urandom);
          op_b[i] = 4'($urandom);
        end else if (pending[i] && $urandom_range(0, 15) == 0) begin
          pending[i] = 1'b0;
        end
      end
    end
    if (rand_mode) rsp_rdy = ($urandom_range(0, 2) != 0);
    drive();
  endtask

  task automatic req(input int i, input logic [3:0] a, input logic [3:0] b);
    op_a[i] = a;
    op_b[i] = b;
    pending[i] = 1'b1;
    drive();
  endtask

  task automatic wait_idle(input string name);
    int n;
    for (n = 0; n < 400; n++) begin
      if (!m_busy && pending == 0 && exp_q.size() == 0) break;
      step();
    end
    chk(n < 400, name, n, 400);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int n;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      acc_flag[i] = 1'b0;
    end
    drive();
    #1 reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // single request from requester 2
    req(2, 4'd3, 4'd5);
    wait_idle("idle_single");
    chk(last_id == 2 && last_prod == 8'd15 && last_err == 1'b0, "tp_single",
        {last_id[3:0], last_prod, last_err}, {4'd2, 8'd15, 1'b0});

    // signed operands from requester 0
    req(0, 4'b1101, 4'd6);
    wait_idle("idle_signed");
    chk(last_id == 0 && last_prod == 8'hEE, "tp_signed", last_prod, 8'hEE);

    // all requesters valid straight out of reset
    pulse_reset();
    grant_log.delete();
    reissue = 1'b1;
    for (int i = 0; i < NREQ; i++) req(i, 4'($urandom), 4'($urandom));
    for (n = 0; n < 300 && grant_log.size() < 5; n++) step();
    reissue = 1'b0;
    pending = '0;
    drive();
    chk(grant_log.size() >= 5, "rr_grants_seen", grant_log.size(), 5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk(grant_log[i] == exp_order[i], "rr_order", grant_log[i], exp_order[i]);
    wait_idle("idle_rr");

    // response backpressure, with a foreign request arriving while busy
    rsp_rdy = 1'b0;
    req(1, 4'd7, 4'd7);
    for (n = 0; n < 50 && !seen_valid; n++) step();
    chk(seen_valid, "bp_valid_seen", seen_valid, 1);
    req(3, 4'd2, 4'b1110);
    repeat (4) step();
    chk(bus.rsp_valid == 1'b1 && bus.busy == 1'b1 && bus.req_ready == 0, "bp_hold",
        {bus.rsp_valid, bus.busy, bus.req_ready}, 6'b110000);
    rsp_rdy = 1'b1;
    drive();
    wait_idle("idle_bp");
    req(2, 4'd1, 4'd4);
    wait_idle("idle_ptr3");

    // reset during RUN drops the operation and returns rr_ptr to 0
    req(0, 4'd5, 4'b1110);
    for (n = 0; n < 20 && !m_busy; n++) step();
    repeat (4) step();
    pulse_reset();
    chk(bus.rsp_valid == 1'b0 && bus.busy == 1'b0, "post_reset_idle",
        {bus.rsp_valid, bus.busy}, 0);
    grant_log.delete();
    req(1, 4'b1000, 4'b1000);
    req(3, 4'd6, 4'd3);
    wait_idle("idle_after_reset");
    chk(grant_log.size() > 0 && grant_log[0] == 1, "rr_after_reset",
        grant_log.size() > 0 ? grant_log[0] : -1, 1);

    // multiplier never finishes
    stuck = 1'b1;
    req(2, 4'd3, 4'd3);
`ifdef MULT_TIMEOUT_EN
    wait_idle("idle_timeout");
    chk(last_err == 1'b1 && last_prod == 8'h00 && last_id == 2, "timeout_rsp",
        {last_err, last_prod}, {1'b1, 8'h00});
    stuck = 1'b0;
`else
    repeat (40) step();
    chk(bus.busy == 1'b1 && bus.rsp_valid == 1'b0, "stuck_run_hold",
        {bus.busy, bus.rsp_valid}, 2'b10);
    stuck = 1'b0;
    pulse_reset();
`endif

    // randomized traffic with random backpressure and withdrawals
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    rsp_rdy = 1'b1;
    drive();
    wait_idle("idle_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/booth_mult_scheduler.md
# booth_mult_scheduler

Round-robin scheduler that shares one `booth_multiplier` datapath among `NREQ` requesters. It accepts a multiply request, drives the multiplier's operand and load (`reset`) pins, waits for `done`, and returns the product tagged with the requester index over a valid/ready response port. It sits between the requesting blocks and a single `booth_multiplier` instance, and is the only driver of that instance's inputs.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 4: operand width, equal to the multiplier's operand width.
- `LOAD_CYCLES`, 2: cycles `mult_load` is held high for each operation, minimum 1.
- `TIMEOUT`, 15: watchdog limit in RUN cycles. Used only with `MULT_TIMEOUT_EN`.

Ports (IDW = clog2(NREQ)):
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, NREQ: request pending, one bit per requester.
- `req_ready`, output, NREQ: one-hot accept, combinational.
- `req_a`, input, NREQ*WIDTH: packed multiplicands; requester i uses bits [i*WIDTH +: WIDTH].
- `req_b`, input, NREQ*WIDTH: packed multipliers, same packing as `req_a`.
- `rsp_valid`, output, 1: response available.
- `rsp_ready`, input, 1: response consumed.
- `rsp_id`, output, IDW: index of the requester that owns the response.
- `rsp_product`, output, 2*WIDTH: product.
- `rsp_err`, output, 1: watchdog abort flag.
- `mult_load`, output, 1: drives the multiplier's `reset` pin.
- `mult_multiplicand`, output, WIDTH: multiplier operand A.
- `mult_multiplier`, output, WIDTH: multiplier operand B.
- `mult_product`, input, 2*WIDTH: multiplier result.
- `mult_done`, input, 1: multiplier completion.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE → LOAD: at least one `req_valid` is high.
  - LOAD → RUN: after `LOAD_CYCLES` cycles.
  - RUN → RESP: `mult_done` is sampled high, or the watchdog expires.
  - RESP → IDLE: `rsp_ready` is high.
- Request acceptance in IDLE:
  - Grant goes to the first `req_valid` bit at or after `rr_ptr`, searching cyclically.
  - `req_ready[grant]` is high in the same cycle. No other `req_ready` bit is ever high.
  - On the handshake edge, `req_a`/`req_b[grant]` and the grant index are registered.
  - Requesters hold valid and operands stable until ready. A requester may drop `req_valid` before it is granted without side effects.
- LOAD:
  - `mult_load` = 1.
  - `mult_multiplicand`/`mult_multiplier` carry the registered operands and stay stable through RUN.
- RUN:
  - `mult_load` = 0.
  - The first RUN cycle ignores `mult_done`, because the multiplier clears it on load.
  - When `mult_done` is sampled high, `mult_product` is captured into `rsp_product` on the same edge.
- RESP:
  - `rsp_valid` = 1, with `rsp_id`, `rsp_product` and `rsp_err` held stable until `rsp_ready`.
  - On the handshake edge, `rr_ptr` ← (grant + 1) mod NREQ.
  - The next grant cannot happen before the cycle after RESP exits. There is no overlap.
- Arithmetic: the product is the multiplier's signed 2*WIDTH result, passed through unmodified.
- `rr_ptr` wraps from NREQ-1 to 0.
- Reset:
  - All outputs are 0, with `rsp_id` = 0 and `mult_load` = 0. State = IDLE, `rr_ptr` = 0.
  - Reset mid-operation aborts the operation with no response. An accepted request is lost and the requester must re-issue it.

## Timing
- All outputs are registered except `req_ready` and `busy`, which are decoded from state.
- Cycle numbering, with the accept edge as cycle 0:
  - LOAD covers cycles 1..LOAD_CYCLES.
  - RUN starts at LOAD_CYCLES+1.
  - `rsp_valid` rises the cycle after `mult_done` is sampled.
- With a 4-cycle multiplier, LOAD_CYCLES = 2, and `rsp_ready` tied high:
  - accept at cycle 0, `rsp_valid` at cycle 8, next accept at cycle 9 at the earliest.
- Simultaneous requests are served in round-robin order. No requester waits more than NREQ-1 foreign operations.
- A `req_valid` that rises while `busy` is high is ignored until IDLE.

## Configuration
- `MULT_TIMEOUT_EN` defined:
  - A counter runs in RUN.
  - If `mult_done` is not sampled high within `TIMEOUT` RUN cycles, the block enters RESP with `rsp_err` = 1 and `rsp_product` = 0.
  - `rsp_id` is still the granted index.
- `MULT_TIMEOUT_EN` undefined:
  - There is no counter, and `rsp_err` is tied to 0.
  - RUN waits for `mult_done` indefinitely.

## Test plan
- Single request, requester 2: `req_a` = 4'd3, `req_b` = 4'd5 → `mult_load` high for 2 cycles, then `rsp_valid` with `rsp_id` = 2, `rsp_product` = 8'd15, `rsp_err` = 0.
- Signed operands, requester 0: `req_a` = 4'b1101 (-3), `req_b` = 4'd6 → `rsp_product` = 8'hEE (-18).
- All four requesters valid from reset, `rsp_ready` = 1 → grants in order 0, 1, 2, 3, then back to 0. `req_ready` is one-hot on each grant.
- Response backpressure: `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid` and data stay stable, no new `req_ready`, `busy` = 1. The handshake on cycle 6 returns the block to IDLE.
- Reset pulse during RUN → all outputs are 0 in the next cycle, no response is issued, `rr_ptr` = 0, and a new request completes normally.
- With `MULT_TIMEOUT_EN`, `mult_done` forced to 0 → `rsp_valid` with `rsp_err` = 1 and product 0 after 15 RUN cycles. Without the macro, the block stays in RUN.
